// File: rtl/syn_accumulator_if.sv
// Port bundle between a synaptic accumulator, its spike source / neuron, and the shared weight-memory bank.
// slave: accumulator side. master: environment side, i.e. the controller, the neuron and the weight memory.
interface syn_accumulator_if #(
  parameter int DW     = 16,
  parameter int INT_DW = 8,
  parameter int N_IN   = 64,
  parameter int AW     = 6
);
  localparam int W = DW + INT_DW;

  logic            start;
  logic [N_IN-1:0] in_spikes;
  logic [AW-1:0]   w_addr;
  logic            w_rd;
  logic [W-1:0]    w_data;
  logic [W-1:0]    spiking_value;
  logic            en;
  logic            busy;

  modport slave (
    input  start, in_spikes, w_data,
    output w_addr, w_rd, spiking_value, en, busy
  );

  modport master (
    output start, in_spikes, w_data,
    input  w_addr, w_rd, spiking_value, en, busy
  );
endinterface

// File: rtl/syn_accumulator.sv
// Serial synaptic accumulator: captures the spike vector on start, sums the weights of active inputs, and strobes en N_IN+1 cycles later.
// No backpressure: the weight memory returns data 1 cycle after w_rd. Define SYN_ACC_SAT_EN to saturate each addition; otherwise additions wrap.
module syn_accumulator #(
  parameter int DW     = 16,
  parameter int INT_DW = 8,
  parameter int N_IN   = 64,
  parameter int AW     = 6
) (
  input  logic               clk,
  input  logic               rst,
  syn_accumulator_if.slave   bus
);
  localparam int W = DW + INT_DW;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [N_IN-1:0]       spk;
  logic signed [W-1:0]   acc;
  logic signed [W-1:0]   addend;
  logic signed [W-1:0]   acc_sum;
  logic [AW-1:0]         idx;
  logic                  rd_d1;
  logic [W-1:0]          spiking_value_q;
  logic                  en_q;
  logic                  busy_q;
  logic                  accept;
  logic                  scan_last;
  logic                  w_rd_c;

  function automatic logic signed [W-1:0] add_w(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
`ifdef SYN_ACC_SAT_EN
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    // Differing top two bits of the extended sum mean signed overflow.
    if (s[W] != s[W-1])
      add_w = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      add_w = s[W-1:0];
`else
    add_w = a + b;
`endif
  endfunction

  // Weight data is only meaningful in the cycle after a read request.
  assign addend  = rd_d1 ? bus.w_data : '0;
  assign acc_sum = add_w(acc, addend);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    scan_last = 1'b0;
    w_rd_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_rd_c = spk[idx];
        if (idx == AW'(N_IN - 1)) begin
          scan_last = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spk             <= '0;
      acc             <= '0;
      idx             <= '0;
      rd_d1           <= 1'b0;
      spiking_value_q <= '0;
      en_q            <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            spk    <= bus.in_spikes;
            acc    <= '0;
            idx    <= '0;
            rd_d1  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          rd_d1 <= w_rd_c;
          idx   <= scan_last ? '0 : idx + 1'b1;
          acc   <= acc_sum;
        end
        DRAIN: begin
          // Folds in the weight of the last scanned input, returned this cycle.
          spiking_value_q <= acc_sum;
          en_q            <= 1'b1;
          busy_q          <= 1'b0;
          rd_d1           <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.w_addr        = idx;
  assign bus.w_rd          = w_rd_c;
  assign bus.spiking_value = spiking_value_q;
  assign bus.en            = en_q;
  assign bus.busy          = busy_q;
endmodule

// File: doc/syn_accumulator.md
# syn_accumulator

Synaptic input accumulator that produces the weighted input for one excitatory neuron per encode time step. On `start` it snapshots the presynaptic spike vector and scans it serially. For each active input it reads that synapse's weight from an external weight memory and sums the weights. It then presents the signed fixed-point sum on `spiking_value` with a one-cycle `en` strobe, and both drive the neuron's `spiking_value`/`en` inputs directly. One instance sits in front of each neuron; instances may share a weight-memory bank.

## Interface
- `DW`, 16: fractional bits of the fixed-point format (Q`INT_DW`.`DW`).
- `INT_DW`, 8: integer bits, sign included; word width `W` = `DW`+`INT_DW` = 24.
- `N_IN`, 64: number of presynaptic inputs; must be ≥ 2.
- `AW`, 6: weight address width; satisfies 2^`AW` ≥ `N_IN`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin one accumulation; sampled only in IDLE.
- `in_spikes`  in  `N_IN`  presynaptic spike vector; captured on the edge that accepts `start`.
- `w_addr`  out  `AW`  weight read address (= current scan index).
- `w_rd`  out  1  weight read request; high only when the scanned input bit is 1.
- `w_data`  in  `W`  signed weight; valid exactly one cycle after `w_rd`.
- `spiking_value`  out  `W`  signed accumulated sum; holds its value between strobes.
- `en`  out  1  one-cycle strobe marking a new `spiking_value`.
- `busy`  out  1  high from start acceptance until the strobe edge.

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE with `start`=1:
  - `spk` ← `in_spikes`, `acc` ← 0, `idx` ← 0, state → SCAN.
- SCAN, each cycle:
  - `w_addr` = `idx` and `w_rd` = `spk[idx]`, both combinational from registers.
  - At the edge, `rd_d1` ← `w_rd` and `idx` ← `idx`+1.
  - At the edge, if `rd_d1`=1, `acc` ← `acc` + `w_data`.
  - At the edge where `idx` = `N_IN`-1, state → DRAIN.
- DRAIN (one cycle):
  - `w_rd`=0.
  - At the edge: `spiking_value` ← `acc` + (`rd_d1` ? `w_data` : 0), `en` ← 1, `busy` ← 0, state → IDLE.
- `en` returns to 0 on the following edge.
- `start` is ignored while `busy`=1. `in_spikes` changes after capture have no effect.
- An all-zero spike vector still completes the scan: `en` pulses with `spiking_value`=0 and `w_rd` is never asserted.
- Arithmetic is signed two's complement at `W` bits. Overflow handling is set by the macro under Configuration.
- `w_data` is ignored in any cycle not following a `w_rd`.
- Reset values: `spiking_value`=0, `en`=0, `busy`=0, `w_rd`=0, `w_addr`=0, state IDLE, `acc`=0, `idx`=0, `rd_d1`=0.
- Reset asserted mid-operation aborts immediately: no `en` pulse, and the prior `spiking_value` is cleared to 0.

## Timing
- Let E0 be the edge that accepts `start`.
- SCAN occupies the cycles between E0 and E`N_IN`; address `i` is driven during the cycle after E`i`.
- DRAIN is the cycle after E`N_IN`. `spiking_value` updates and `en` rises at E(`N_IN`+1).
- `en` is high for exactly one cycle and falls at E(`N_IN`+2).
- `busy` is high from E0 to E(`N_IN`+1).
- The earliest next `start` acceptance is at E(`N_IN`+2). With `start` held high, `en` pulses every `N_IN`+2 cycles.
- Weight memory: synchronous read with 1-cycle latency and no backpressure.

## Configuration
- `SYN_ACC_SAT_EN` defined:
  - Every addition saturates to 0x7FFFFF / 0x800000 (for `W`=24).
  - Once saturated, the sum can move back only through subsequent opposite-sign weights.
- `SYN_ACC_SAT_EN` undefined: additions wrap modulo 2^`W`.

## Test plan
- Basic sum: `in_spikes` bits {0,5,63} set, w[0]=0x010000, w[5]=0x020000, w[63]=0x030000 → exactly 3 `w_rd` pulses at addresses 0, 5, 63; `en` at E65 with `spiking_value`=0x060000; `busy` low at E65.
- Zero vector: `in_spikes`=0 → `w_rd` never high; `en` at E65 with `spiking_value`=0.
- Overflow: all 64 bits set, all weights 0x100000 → 0x7FFFFF with `SYN_ACC_SAT_EN`, 0x000000 without. All weights 0xF00000 → 0x800000 with the macro, 0x000000 without.
- Mid-scan interference: `start` re-pulsed and `in_spikes` flipped to all-ones at cycle 10 → ignored; the result equals the first-capture sum and there is one `en`.
- Reset mid-scan: `rst` at cycle 20 → `busy`, `en`, `w_rd`, `spiking_value` go 0 immediately with no strobe; a following start with bits {1} and w[1]=0xFF0000 → 0xFF0000 at E65.
- Back-to-back: `start` held high for 3 frames → `en` at E65, E131, E197; each frame's value matches that frame's captured vector.
